window_scan_ctrl: RTL

Sequencer for the 3x3 window frame memory in the filter datapath. On a start request it drives the memory's `rd` strobe across the full output raster, one window per cycle, and tracks the current window row/column. It generates the matching `wr` strobe and write address, delayed by the filter pipeline latency, and reports busy/done. Downstream back-pressure pauses it without losing or duplicating any window.

---
 rtl/window_scan_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/window_scan_ctrl.sv
// Raster sequencer for the 3x3 window frame memory: issues one window read per
// cycle, mirrors each read as a write PIPE_LAT cycles later, and reports busy/done.
module window_scan_ctrl #(
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int PIPE_LAT = 3,
  parameter int AW       = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  output logic          rd,
  output logic [AW-1:0] rd_row,
  output logic [AW-1:0] rd_col,
  output logic          wr,
  output logic [AW-1:0] wr_row,
  output logic [AW-1:0] wr_col,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
  } slot_t;

  localparam logic [AW-1:0] ROW_LAST = AW'(IMG_H - 1);
  localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 1);

  state_t        state, state_nxt;
  slot_t         dly [PIPE_LAT];
  logic          rd_nxt, busy_nxt, done_nxt;
  logic [AW-1:0] row_nxt, col_nxt;
  logic          last_win, pending;

  assign last_win = (rd_row == ROW_LAST) && (rd_col == COL_LAST);

  // Entries still ahead of the final write stage; the frame is finished once
  // these are empty and the last result sits in the output stage.
  always_comb begin
    pending = 1'b0;
    for (int k = 0; k < PIPE_LAT - 1; k++) pending = pending | dly[k].v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rd     <= 1'b0;
      rd_row <= '0;
      rd_col <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      rd     <= rd_nxt;
      rd_row <= row_nxt;
      rd_col <= col_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (rd && last_win) state_nxt = DRAIN;
      DRAIN:   if (!pending) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters advance only past a window that was actually read, so a stall
  // leaves them pointing at the next window to issue.
  always_comb begin
    rd_nxt   = 1'b0;
    row_nxt  = rd_row;
    col_nxt  = rd_col;
    busy_nxt = busy;
    done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          rd_nxt   = 1'b1;
          row_nxt  = '0;
          col_nxt  = '0;
          busy_nxt = 1'b1;
        end
      end
      SCAN: begin
        if (rd && !last_win) begin
          if (rd_col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = rd_row + AW'(1);
          end else begin
            col_nxt = rd_col + AW'(1);
          end
        end
        rd_nxt = !(rd && last_win) && !stall;
      end
      DRAIN:   if (!pending) done_nxt = 1'b1;
      DONE:    busy_nxt = 1'b0;
      default: busy_nxt = 1'b0;
    endcase
  end

  // Coordinates move only with valid entries, so the output stage keeps the
  // last written coordinate through write bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE_LAT; k++) dly[k] <= '0;
    end else begin
      dly[0].v <= rd;
      if (rd) begin
        dly[0].row <= rd_row;
        dly[0].col <= rd_col;
      end
      for (int k = 1; k < PIPE_LAT; k++) begin
        dly[k].v <= dly[k-1].v;
        if (dly[k-1].v) begin
          dly[k].row <= dly[k-1].row;
          dly[k].col <= dly[k-1].col;
        end
      end
    end
  end

  assign wr     = dly[PIPE_LAT-1].v;
  assign wr_row = dly[PIPE_LAT-1].row;
  assign wr_col = dly[PIPE_LAT-1].col;

endmodule
